// File: rtl/tft_fb_arbiter_pkg.sv
// Shared constants, FSM state type and line base-address helper for the
// TFT frame-buffer arbiter.
package tft_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned AW       = 19;
  localparam int unsigned DW       = 16;
  localparam int unsigned YW       = 9;
  localparam int unsigned CW       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

  // y*800 as shift-add: 512 + 256 + 32
  function automatic logic [AW-1:0] line_base(input logic [YW-1:0] y);
    logic [AW-1:0] yw;
    yw = AW'(y);
    return (yw << 9) + (yw << 8) + (yw << 5);
  endfunction

endpackage

// File: rtl/tft_fb_arbiter_if.sv
// Host write channel (valid/ready with address and data).
//   master: drives valid/addr/data, observes ready
//   slave : observes valid/addr/data, drives ready
interface tft_fb_arbiter_if;
  import tft_pkg::*;

  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/tft_fb_arbiter_line_addr.sv
// Registered frame-buffer read address / column generator for one line fetch.
//   i_start   : load base = y*800 and column 0
//   i_advance : step address and column by one
//   o_addr    : current read address, o_col current column, o_last column 799
module tft_line_addr
  import tft_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [YW-1:0] i_y,
  input  logic          i_advance,
  output logic [AW-1:0] o_addr,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] col_q, col_d;

  // next address/column
  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    if (i_start) begin
      addr_d = line_base(i_y);
      col_d  = '0;
    end else if (i_advance) begin
      addr_d = addr_q + AW'(1);
      col_d  = col_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;
      col_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
    end
  end

  assign o_addr = addr_q;
  assign o_col  = col_q;
  assign o_last = (col_q == CW'(H_ACTIVE - 1));

endmodule

// File: rtl/tft_fb_arbiter.sv
// Frame-buffer arbiter and line-prefetch sequencer. The display fetch owns the
// single-port RAM while a line is streaming; host writes get the RAM only when
// idle and no fetch is being requested.
//   i_fetch_req/i_fetch_y : start a line fetch (y >= 480 ignored)
//   i_host_*/o_host_ready : host write channel, zero-latency acceptance
//   o_mem_* / i_mem_rdata : single-port RAM, 1-cycle read latency
//   o_lb_*                : ping-pong line-buffer write port
//   o_fetch_done/o_underrun : line complete / fetch aborted by a new request
module tft_fb_arbiter
  import tft_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_fetch_req,
  input  logic [YW-1:0] i_fetch_y,
  input  logic          i_host_valid,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_data,
  output logic          o_host_ready,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_lb_we,
  output logic          o_lb_bank,
  output logic [CW-1:0] o_lb_addr,
  output logic [DW-1:0] o_lb_data,
  output logic          o_fetch_done,
  output logic          o_underrun
);

  fsm_state_e    state_q, state_d;
  logic          bank_q, bank_d;
  logic          lb_we_q, lb_we_d;
  logic [CW-1:0] lb_addr_q, lb_addr_d;
  logic          done_q, done_d;
  logic          under_q, under_d;

  logic          req_ok;
  logic          start;
  logic          advance;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] col;
  logic          last_col;
  logic          rd_active;
  logic          host_fire;

  assign req_ok = i_fetch_req && (i_fetch_y < YW'(V_ACTIVE));

  tft_line_addr u_line_addr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (start),
    .i_y       (i_fetch_y),
    .i_advance (advance),
    .o_addr    (rd_addr),
    .o_col     (col),
    .o_last    (last_col)
  );

  // next state, strobes and pulses
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    start   = 1'b0;
    advance = 1'b0;
    // a new request discards the word returning next cycle
    lb_we_d   = (state_q == ST_FETCH) && !req_ok;
    lb_addr_d = lb_we_d ? col : '0;
    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          state_d = ST_FETCH;
          start   = 1'b1;
          bank_d  = ~bank_q;
        end
      end
      ST_FETCH: begin
        if (req_ok) begin
          under_d = 1'b1;
          start   = 1'b1;
          bank_d  = ~bank_q;
        end else if (last_col) begin
          state_d = ST_DRAIN;
          done_d  = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (req_ok) begin
          state_d = ST_FETCH;
          under_d = 1'b1;
          start   = 1'b1;
          bank_d  = ~bank_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      bank_q    <= 1'b0;
      lb_we_q   <= 1'b0;
      lb_addr_q <= '0;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      lb_we_q   <= lb_we_d;
      lb_addr_q <= lb_addr_d;
      done_q    <= done_d;
      under_q   <= under_d;
    end
  end

  // host owns the RAM only in IDLE with no fetch pending; reads and writes are exclusive
  assign rd_active    = (state_q == ST_FETCH);
  assign o_host_ready = i_rst_n && (state_q == ST_IDLE) && !req_ok;
  assign host_fire    = o_host_ready && i_host_valid;

  assign o_mem_en    = rd_active || host_fire;
  assign o_mem_we    = host_fire;
  assign o_mem_addr  = rd_active ? rd_addr : (host_fire ? i_host_addr : '0);
  assign o_mem_wdata = host_fire ? i_host_data : '0;

  assign o_lb_we      = lb_we_q;
  assign o_lb_bank    = bank_q;
  assign o_lb_addr    = lb_addr_q;
  assign o_lb_data    = lb_we_q ? i_mem_rdata : '0;
  assign o_fetch_done = done_q;
  assign o_underrun   = under_q;

endmodule

// File: tb/tb_tft_fb_arbiter.sv
// Self-checking bench for tft_fb_arbiter: directed scenarios plus a random
// phase, compared cycle by cycle against a timeline model of the fetch.
module tb_tft_fb_arbiter;
  import tft_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [8:0]    fetch_y = '0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          lb_we, lb_bank, fetch_done, underrun;
  logic [9:0]    lb_addr;
  logic [DW-1:0] lb_data;

  tft_fb_arbiter_if hif ();

  always #5 clk = ~clk;

  tft_fb_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fetch_req  (fetch_req),
    .i_fetch_y    (fetch_y),
    .i_host_valid (hif.valid),
    .i_host_addr  (hif.addr),
    .i_host_data  (hif.data),
    .o_host_ready (hif.ready),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_lb_we      (lb_we),
    .o_lb_bank    (lb_bank),
    .o_lb_addr    (lb_addr),
    .o_lb_data    (lb_data),
    .o_fetch_done (fetch_done),
    .o_underrun   (underrun)
  );

  // frame-buffer RAM: unwritten words hold a pattern derived from the address
  logic [DW-1:0] ram [logic [AW-1:0]];

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    if (ram.exists(a)) return ram[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= rd_word(mem_addr);

  always @(posedge clk)
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one active fetch described by its request cycle
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } hw_t;
  hw_t hq[$];
  bit  host_en = 0;
  bit  busy = 0;
  bit  fu   = 0;
  bit  bank = 0;
  int  s    = 0;
  int  fy   = 0;
  int  cyc  = 0;

  // one clock cycle: drive at posedge+1, check at negedge, update model at posedge
  task automatic cycle(input bit req, input logic [8:0] y);
    bit hv, idle, req_ok, rd, hw, lbw;
    int off, ea;
    fetch_req = req;
    fetch_y   = y;
    hv = host_en && (hq.size() > 0);
    hif.valid = hv;
    hif.addr  = hv ? hq[0].a : AW'($urandom_range(0, 383999));
    hif.data  = hv ? hq[0].d : DW'($urandom);
    #4;
    off    = cyc - s;
    idle   = !busy || off >= 802;
    req_ok = req && (y < 9'd480);
    rd     = busy && off >= 1 && off <= 800;
    hw     = idle && !req_ok && hv;
    lbw    = busy && off >= 2 && off <= 801;
    ea     = rd ? fy * 800 + off - 1 : (hw ? int'(hq[0].a) : 0);
    check("ready", 32'(hif.ready), 32'(idle && !req_ok));
    check("mem_en", 32'(mem_en), 32'(rd || hw));
    check("mem_we", 32'(mem_we), 32'(hw));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_wdata", 32'(mem_wdata), hw ? 32'(hq[0].d) : 32'd0);
    check("lb_we", 32'(lb_we), 32'(lbw));
    check("lb_addr", 32'(lb_addr), lbw ? 32'(off - 2) : 32'd0);
    check("lb_data", 32'(lb_data), lbw ? 32'(rd_word(AW'(fy * 800 + off - 2))) : 32'd0);
    check("lb_bank", 32'(lb_bank), 32'(bank));
    check("done", 32'(fetch_done), 32'(busy && off == 801));
    check("underrun", 32'(underrun), 32'(busy && fu && off == 1));
    @(posedge clk);
    if (hw) void'(hq.pop_front());
    if (req_ok) begin
      fu   = !idle;
      busy = 1;
      s    = cyc;
      fy   = int'(y);
      bank = ~bank;
    end
    cyc++;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, 32'(mem_en), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_lbwe"}, 32'(lb_we), 0);
    check({tag, "_lbaddr"}, 32'(lb_addr), 0);
    check({tag, "_lbdata"}, 32'(lb_data), 0);
    check({tag, "_bank"}, 32'(lb_bank), 0);
    check({tag, "_done"}, 32'(fetch_done), 0);
    check({tag, "_under"}, 32'(underrun), 0);
    check({tag, "_ready"}, 32'(hif.ready), 0);
  endtask

  task automatic push_host(input int n);
    hw_t w;
    for (int i = 0; i < n; i++) begin
      w.a = AW'($urandom_range(0, 383999));
      w.d = DW'($urandom);
      hq.push_back(w);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'd0);
  endtask

  initial begin
    hif.valid = 1'b0;
    hif.addr  = '0;
    hif.data  = '0;
    #2;
    check_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // full line y=0 with the host idle
    idle_cycles(3);
    cycle(1'b1, 9'd0);
    idle_cycles(805);

    // last line: addresses 383200..383999
    cycle(1'b1, 9'd479);
    idle_cycles(805);

    // host stream of 10 with a fetch arriving after the 4th accepted write
    push_host(10);
    host_en = 1;
    idle_cycles(4);
    cycle(1'b1, 9'd17);
    idle_cycles(810);
    check("host_drain", 32'(hq.size()), 0);

    // abort at column 400: underrun, restart on the other bank from column 0
    host_en = 0;
    cycle(1'b1, 9'd100);
    idle_cycles(400);
    cycle(1'b1, 9'd200);
    idle_cycles(805);

    // out-of-range line is ignored while the host keeps writing
    push_host(4);
    host_en = 1;
    idle_cycles(1);
    cycle(1'b1, 9'd480);
    cycle(1'b1, 9'd511);
    idle_cycles(4);
    check("host_drain2", 32'(hq.size()), 0);
    host_en = 0;

    // async reset in the middle of a fetch
    cycle(1'b1, 9'd300);
    idle_cycles(300);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #4;
    rst_n = 1'b1;
    busy = 0;
    bank = 0;
    fu   = 0;
    @(posedge clk); #1;
    cyc++;
    idle_cycles(2);

    // random traffic: sparse fetch requests, occasional underruns and bad lines
    for (int i = 0; i < 6000; i++) begin
      bit r;
      if (hq.size() < 3) push_host(int'($urandom_range(0, 6)));
      if ($urandom_range(0, 15) == 0) host_en = ~host_en;
      r = ($urandom_range(0, 499) == 0);
      cycle(r, 9'($urandom_range(0, 511)));
    end
    idle_cycles(805);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
